record_store_arbiter: RTL and testbench

- Owns the play-record ring buffer and shares its single read/write port among the play page (writer) and the display pages (history, leaderboard; readers).
- Readers address records by recency (index 0 = newest), so pages never track physical slots.
- Sequences bulk clear on request.
- Sits between the page modules and the record RAM on the program clock.

---
 rtl/record_store_if.sv | 31 +++
 rtl/record_store_arbiter.sv | 146 ++++++++++++++
 tb/tb_record_store_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/record_store_if.sv
// Record store bus: page-side requests/grants between page modules and the arbiter.
interface record_store_if #(
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned REC_W  = 256
);
    logic                  clr_req;
    logic                  clr_done;
    logic                  wr_req;
    logic [REC_W-1:0]      wr_data;
    logic                  wr_ack;
    logic [NUM_RD-1:0]     rd_req;
    logic [NUM_RD*8-1:0]   rd_idx;
    logic [NUM_RD-1:0]     rd_gnt;
    logic [NUM_RD-1:0]     rd_valid;
    logic                  rd_miss;
    logic [REC_W-1:0]      rd_data;
    logic [7:0]            record_count;
    logic                  busy;

    // Page modules: issue requests, observe grants and responses.
    modport master (
        output clr_req, wr_req, wr_data, rd_req, rd_idx,
        input  clr_done, wr_ack, rd_gnt, rd_valid, rd_miss, rd_data, record_count, busy
    );

    // Arbiter: owns the ring buffer and answers requests.
    modport slave (
        input  clr_req, wr_req, wr_data, rd_req, rd_idx,
        output clr_done, wr_ack, rd_gnt, rd_valid, rd_miss, rd_data, record_count, busy
    );
endinterface

// File: rtl/record_store_arbiter.sv
// Play-record ring buffer with a single shared port: one writer, NUM_RD
// recency-addressed readers, and a sequenced bulk clear.
// Optional build macro RECORD_ARB_RR_EN: round-robin reader arbitration
// (otherwise fixed priority, lowest reader index wins).
module record_store_arbiter #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned REC_W  = 256
) (
    input  logic          clk,
    input  logic          rst,
    record_store_if.slave bus
);
    localparam int unsigned AW = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
    localparam int unsigned RW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

    state_t              state;
    state_t              state_nx;
    logic [AW-1:0]       head;
    logic [AW-1:0]       clr_idx;
    logic [7:0]          count;
    logic [REC_W-1:0]    mem [DEPTH];

    logic                clr_gnt;
    logic                wr_gnt;
    logic                rd_any;
    logic [RW-1:0]       rd_sel;
    logic [RW-1:0]       cand;
    logic [NUM_RD-1:0]   rd_gnt_c;
    logic [7:0]          idx_sel;
    logic [AW-1:0]       rd_addr;
    logic                rd_hit;
    logic                clr_last;

`ifdef RECORD_ARB_RR_EN
    logic [RW-1:0]       rr_ptr;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    assign clr_last = (clr_idx == AW'(DEPTH - 1));

    // Next state: clear grant enters CLEAR, last slot returns to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (clr_gnt)  state_nx = ST_CLEAR;
            ST_CLEAR: if (clr_last) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Grant decode: one grant per IDLE cycle, clear > write > readers.
    always_comb begin
        clr_gnt  = 1'b0;
        wr_gnt   = 1'b0;
        rd_any   = 1'b0;
        rd_sel   = '0;
        cand     = '0;
        rd_gnt_c = '0;
        if (rst && state == ST_IDLE) begin
            if (bus.clr_req) begin
                clr_gnt = 1'b1;
            end else if (bus.wr_req) begin
                wr_gnt = 1'b1;
            end else begin
                for (int k = 0; k < int'(NUM_RD); k++) begin
`ifdef RECORD_ARB_RR_EN
                    cand = RW'((32'(rr_ptr) + 32'(k)) % NUM_RD);
`else
                    cand = RW'(k);
`endif
                    if (!rd_any && bus.rd_req[cand]) begin
                        rd_any = 1'b1;
                        rd_sel = cand;
                    end
                end
                if (rd_any) rd_gnt_c = NUM_RD'(1) << rd_sel;
            end
        end
    end

    assign idx_sel = bus.rd_idx[{rd_sel, 3'b000} +: 8];
    assign rd_addr = head - AW'(1) - idx_sel[AW-1:0];
    assign rd_hit  = (idx_sel < count);

    assign bus.rd_gnt       = rd_gnt_c;
    assign bus.busy         = (state == ST_CLEAR);
    assign bus.record_count = count;

    // Head/count bookkeeping, clear sequencing and registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= '0;
            count        <= '0;
            clr_idx      <= '0;
            bus.wr_ack   <= 1'b0;
            bus.clr_done <= 1'b0;
            bus.rd_valid <= '0;
            bus.rd_miss  <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.wr_ack   <= wr_gnt;
            bus.clr_done <= 1'b0;
            bus.rd_valid <= rd_gnt_c;
            if (wr_gnt) begin
                head <= head + AW'(1);
                if (count < 8'(DEPTH)) count <= count + 8'd1;
            end
            if (clr_gnt) clr_idx <= '0;
            if (state == ST_CLEAR) begin
                clr_idx <= clr_idx + AW'(1);
                if (clr_last) begin
                    head         <= '0;
                    count        <= '0;
                    bus.clr_done <= 1'b1;
                end
            end
            if (rd_any) begin
                bus.rd_miss <= !rd_hit;
                bus.rd_data <= rd_hit ? mem[rd_addr] : '0;
            end
        end
    end

    // Record RAM write port: appends and clear zeroing (contents not reset).
    always_ff @(posedge clk) begin
        if (wr_gnt)                 mem[head]    <= bus.wr_data;
        else if (state == ST_CLEAR) mem[clr_idx] <= '0;
    end

`ifdef RECORD_ARB_RR_EN
    // Round-robin pointer: next search starts after the last granted reader.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        rr_ptr <= '0;
        else if (rd_any) rr_ptr <= RW'((32'(rd_sel) + 32'd1) % NUM_RD);
    end
`endif

endmodule

// File: tb/tb_record_store_arbiter.sv
// Directed self-checking bench for record_store_arbiter (DEPTH=16, NUM_RD=2).
module tb_record_store_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    record_store_if #(.NUM_RD(2), .REC_W(256)) bus ();

    record_store_arbiter #(.DEPTH(16), .NUM_RD(2), .REC_W(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [255:0] rec(input int n);
        return {8{32'hC0DE_0000 + 32'(n)}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [255:0] data, input string tag);
        bus.wr_req  = 1'b1;
        bus.wr_data = data;
        step();
        bus.wr_req  = 1'b0;
        chk({tag, "_ack"}, 256'(bus.wr_ack), 256'(1));
    endtask

    task automatic do_read(input int r, input logic [7:0] idx, input logic exp_miss,
                           input logic [255:0] exp_data, input string tag);
        bus.rd_req = 2'(32'd1 << r);
        bus.rd_idx = 16'(idx) << (8 * r);
        #1;
        chk({tag, "_gnt"}, 256'(bus.rd_gnt), 256'(2'(32'd1 << r)));
        step();
        bus.rd_req = '0;
        chk({tag, "_valid"}, 256'(bus.rd_valid), 256'(2'(32'd1 << r)));
        chk({tag, "_miss"}, 256'(bus.rd_miss), 256'(exp_miss));
        chk({tag, "_data"}, bus.rd_data, exp_data);
    endtask

    initial begin
        logic [1:0] exp_g;
        logic       got;
        logic       seen;
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        bus.clr_req  = 1'b0;
        bus.wr_req   = 1'b0;
        bus.wr_data  = '0;
        bus.rd_req   = '0;
        bus.rd_idx   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 256'(bus.record_count), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_wr_ack", 256'(bus.wr_ack), 256'(0));
        chk("rst_clr_done", 256'(bus.clr_done), 256'(0));
        chk("rst_rd_valid", 256'(bus.rd_valid), 256'(0));
        chk("rst_rd_data", bus.rd_data, 256'(0));
        rst = 1'b1;
        step();

        // Write A, B, C back to back; read by recency
        do_write(rec('hA), "wr_a");
        do_write(rec('hB), "wr_b");
        do_write(rec('hC), "wr_c");
        chk("count3", 256'(bus.record_count), 256'(3));
        do_read(0, 8'd0, 1'b0, rec('hC), "rd_idx0");
        chk("wr_ack_drop", 256'(bus.wr_ack), 256'(0));
        do_read(0, 8'd2, 1'b0, rec('hA), "rd_idx2");
        do_read(0, 8'd3, 1'b1, 256'(0), "rd_idx3_miss");

        // Saturation and overwrite of oldest
        for (int k = 0; k < 20; k++) do_write(rec(100 + k), "wr_r");
        chk("count_sat", 256'(bus.record_count), 256'(16));
        do_read(0, 8'd0, 1'b0, rec(119), "sat_idx0");
        do_read(0, 8'd15, 1'b0, rec(104), "sat_idx15");
        do_read(1, 8'd16, 1'b1, 256'(0), "sat_idx16_miss");

        // Write beats both readers, then reader 0, then reader 1
        bus.wr_req  = 1'b1;
        bus.wr_data = rec('hEE);
        bus.rd_req  = 2'b11;
        bus.rd_idx  = '0;
        #1;
        chk("arb_wr_first", 256'(bus.rd_gnt), 256'(0));
        step();
        bus.wr_req = 1'b0;
        chk("arb_wr_ack", 256'(bus.wr_ack), 256'(1));
        #1;
        chk("arb_gnt_r0", 256'(bus.rd_gnt), 256'(2'b01));
        step();
        bus.rd_req = 2'b10;
        chk("arb_valid_r0", 256'(bus.rd_valid), 256'(2'b01));
        chk("arb_data_r0", bus.rd_data, rec('hEE));
        #1;
        chk("arb_gnt_r1", 256'(bus.rd_gnt), 256'(2'b10));
        step();
        bus.rd_req = '0;
        chk("arb_valid_r1", 256'(bus.rd_valid), 256'(2'b10));

        // Both readers held for four grants
        bus.rd_req = 2'b11;
        bus.rd_idx = {8'd2, 8'd1};
        for (int i = 0; i < 4; i++) begin
`ifdef RECORD_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            #1;
            chk("hold_gnt", 256'(bus.rd_gnt), 256'(exp_g));
            step();
            if (i == 3) bus.rd_req = '0;
            chk("hold_valid", 256'(bus.rd_valid), 256'(exp_g));
            chk("hold_data", bus.rd_data, (exp_g == 2'b01) ? rec(119) : rec(118));
        end

        // Async reset, then five records and a full clear
        #2;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
        for (int k = 0; k < 5; k++) do_write(rec(200 + k), "wr_e");
        chk("count5", 256'(bus.record_count), 256'(5));
        bus.clr_req = 1'b1;
        bus.rd_req  = 2'b01;
        bus.rd_idx  = '0;
        #1;
        chk("clr_beats_rd", 256'(bus.rd_gnt), 256'(0));
        chk("clr_busy_grant", 256'(bus.busy), 256'(0));
        step();
        bus.clr_req = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk("clr_busy", 256'(bus.busy), 256'(1));
            chk("clr_no_done", 256'(bus.clr_done), 256'(0));
            chk("clr_no_rdgnt", 256'(bus.rd_gnt), 256'(0));
            step();
        end
        chk("clr_done_pulse", 256'(bus.clr_done), 256'(1));
        chk("clr_busy_end", 256'(bus.busy), 256'(0));
        chk("clr_count0", 256'(bus.record_count), 256'(0));
        got = 1'b0;
        for (int t = 0; t < 4 && !got; t++) begin
            #1;
            if (bus.rd_gnt[0]) got = 1'b1;
            else step();
        end
        chk("clr_rd_granted", 256'(got), 256'(1));
        step();
        bus.rd_req = '0;
        chk("clr_rd_valid", 256'(bus.rd_valid), 256'(2'b01));
        chk("clr_rd_miss", 256'(bus.rd_miss), 256'(1));
        chk("clr_rd_data", bus.rd_data, 256'(0));
        chk("clr_done_one", 256'(bus.clr_done), 256'(0));

        // Reset in the middle of a clear
        do_write(rec('hD1), "wr_d1");
        do_read(0, 8'd0, 1'b0, rec('hD1), "rd_d1");
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        repeat (5) step();
        chk("mid_busy_before", 256'(bus.busy), 256'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("mid_busy", 256'(bus.busy), 256'(0));
        chk("mid_count", 256'(bus.record_count), 256'(0));
        chk("mid_clr_done", 256'(bus.clr_done), 256'(0));
        chk("mid_rd_data", bus.rd_data, 256'(0));
        chk("mid_rd_valid", 256'(bus.rd_valid), 256'(0));
        chk("mid_rd_gnt", 256'(bus.rd_gnt), 256'(0));
        step();
        step();
        rst  = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (bus.clr_done || bus.busy) seen = 1'b1;
            step();
        end
        chk("mid_no_clr_done", 256'(seen), 256'(0));
        do_write(rec('hD), "wr_d");
        do_read(0, 8'd0, 1'b0, rec('hD), "rd_d");
        chk("mid_count1", 256'(bus.record_count), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
